// File: rtl/acia_brgen_nco.sv
// acia_brgen_nco -- phase-accumulator baud-rate generator for the ACIA.
// Produces a 16x oversample strobe (TICK16), a bit strobe (TICK1) and a
// baud-rate square wave (BCLK) from any XTLI frequency. R_SBR selects a
// 6551 rate; R_SBR = 0 selects a programmable increment when the
// ACIA_BRGEN_CUST_EN macro is defined, and gives no ticks otherwise.
// Any change of rate (or a custom write while custom is selected) clears
// the phase so the shifters start from a clean bit boundary.

module acia_brgen_nco #(
   parameter int unsigned CLK_HZ = 12000000,
   parameter int unsigned ACC_W  = 24
) (
   input  logic             XTLI,
   input  logic             RESET,
   input  logic [3:0]       R_SBR,
   input  logic [ACC_W-1:0] CUST_INC,
   input  logic             CUST_WE,
   output logic             TICK16,
   output logic             TICK1,
   output logic             BCLK
);

   // Phase increment for a rate given in centibaud, rounded half-up.
   function automatic logic [ACC_W-1:0] calc_inc(input longint unsigned cb);
      longint unsigned num;
      longint unsigned den;
      num = ((cb * 64'd16) << ACC_W) + (64'(CLK_HZ) * 64'd50);
      den = 64'(CLK_HZ) * 64'd100;
      return ACC_W'(num / den);
   endfunction

   // Power-on custom increment: 115200 baud at this clock, rounded.
   function automatic logic [ACC_W-1:0] calc_cust_rst();
      longint unsigned num;
      num = ((64'd115200 * 64'd16) << ACC_W) + (64'(CLK_HZ) / 64'd2);
      return ACC_W'(num / 64'(CLK_HZ));
   endfunction

   // Entry 0 is unused here; R_SBR = 0 is resolved separately.
   localparam logic [ACC_W-1:0] INC_TABLE [16] = '{
      '0,
      calc_inc(64'd5000),    calc_inc(64'd7500),    calc_inc(64'd10992),
      calc_inc(64'd13458),   calc_inc(64'd15000),   calc_inc(64'd30000),
      calc_inc(64'd60000),   calc_inc(64'd120000),  calc_inc(64'd180000),
      calc_inc(64'd240000),  calc_inc(64'd360000),  calc_inc(64'd480000),
      calc_inc(64'd720000),  calc_inc(64'd960000),  calc_inc(64'd1920000)
   };

   localparam logic [ACC_W-1:0] CUST_RST = calc_cust_rst();
   localparam logic [ACC_W-1:0] INC_MAX  = {1'b1, {(ACC_W-1){1'b0}}};

   logic [3:0]       r_sbr_q;
   logic [ACC_W-1:0] acc_q;
   logic [3:0]       sub_q;
   logic [ACC_W-1:0] inc_sel;
   logic [ACC_W-1:0] inc_active;
   logic [ACC_W:0]   acc_sum;
   logic             carry;
   logic             resync;

`ifdef ACIA_BRGEN_CUST_EN
   logic [ACC_W-1:0] cust_q;

   // Custom increment register, writable regardless of the current rate.
   always_ff @(posedge XTLI or negedge RESET) begin
      if (!RESET)
         cust_q <= CUST_RST;
      else if (CUST_WE)
         cust_q <= CUST_INC;
   end

   // A new custom value while custom is selected restarts the phase.
   always_comb begin
      resync = (R_SBR != r_sbr_q) || (CUST_WE && (R_SBR == 4'd0));
   end

   // Table lookup, with slot 0 taken from the custom register.
   always_comb begin
      inc_sel = INC_TABLE[r_sbr_q];
      if (r_sbr_q == 4'd0)
         inc_sel = cust_q;
   end
`else
   logic unused_cust;

   assign unused_cust = ^{CUST_INC, CUST_WE, CUST_RST};

   // Only a rate change restarts the phase when no custom register exists.
   always_comb begin
      resync = (R_SBR != r_sbr_q);
   end

   // Table lookup; slot 0 holds zero so R_SBR = 0 stays silent.
   always_comb begin
      inc_sel = INC_TABLE[r_sbr_q];
   end
`endif

   // Clamp so a carry can occur at most every other cycle, then accumulate.
   always_comb begin
      inc_active = inc_sel;
      if (inc_sel > INC_MAX)
         inc_active = INC_MAX;
      acc_sum = {1'b0, acc_q} + {1'b0, inc_active};
      carry   = acc_sum[ACC_W];
   end

   // Phase, sub-bit counter and registered strobes; resync clears them all.
   always_ff @(posedge XTLI or negedge RESET) begin
      if (!RESET) begin
         r_sbr_q <= 4'd0;
         acc_q   <= '0;
         sub_q   <= 4'd0;
         TICK16  <= 1'b0;
         TICK1   <= 1'b0;
         BCLK    <= 1'b0;
      end else if (resync) begin
         r_sbr_q <= R_SBR;
         acc_q   <= '0;
         sub_q   <= 4'd0;
         TICK16  <= 1'b0;
         TICK1   <= 1'b0;
         BCLK    <= 1'b0;
      end else begin
         acc_q  <= acc_sum[ACC_W-1:0];
         TICK16 <= carry;
         TICK1  <= carry && (sub_q == 4'd15);
         if (carry) begin
            sub_q <= sub_q + 4'd1;
            if ((sub_q == 4'd15) || (sub_q == 4'd7))
               BCLK <= ~BCLK;
         end
      end
   end

endmodule
